imc_engine: RTL and testbench
=============================

IMC_ENGINE -- requirements
Module: imc_engine

Interface
REQ-001 SHALL have parameter DW, default 4: operand width in bits.
REQ-002 SHALL have parameter N, default 16: vector length; N SHALL be a multiple of LANES.
REQ-003 SHALL have parameter BANKS, default 4: number of weight banks.
REQ-004 SHALL have parameter LANES, default 4: multiply-accumulates per cycle.
REQ-005 SHALL have localparam RW = 2*DW + $clog2(N), the result width.
REQ-006 SHALL have clk, input, 1 bit: the single clock.
REQ-007 SHALL have rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have wr_valid, input, 1 bit: write request.
REQ-009 SHALL have wr_ready, output, 1 bit: write accepted; high only in IDLE.
REQ-010 SHALL have wr_sel, input, $clog2(BANKS+1) bits: 0 selects the x vector, k selects weight bank k-1.
REQ-011 SHALL have wr_data, input, N*DW bits: element i occupies bits [i*DW +: DW].
REQ-012 SHALL have start, input, 1 bit: single-cycle compute request.
REQ-013 SHALL have busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have res_valid, output, 1 bit: a result is presented.
REQ-015 SHALL have res_ready, input, 1 bit: the consumer accepts the result.
REQ-016 SHALL have res_data, output, RW bits: dot product of x with one bank.
REQ-017 SHALL have res_bank, output, $clog2(BANKS) bits: bank index of res_data.
REQ-018 SHALL have done, output, 1 bit: one-cycle pulse after the last bank's result is accepted.

Function
REQ-019 Storage SHALL be one x register file and BANKS weight register files, each N x DW.
REQ-020 A write SHALL occur when wr_valid and wr_ready are both high; the data is visible from the next cycle.
REQ-021 A write with wr_sel > BANKS SHALL be accepted and discarded.
REQ-022 The FSM SHALL have the states IDLE, MAC, OUT and DONE.
REQ-023 IDLE SHALL move to MAC on start; start while busy SHALL be ignored.
REQ-024 When wr_valid and start coincide in IDLE, the write SHALL be applied and the computation SHALL use the new data.
REQ-025 MAC SHALL process LANES elements per cycle, indices chunk*LANES to chunk*LANES+LANES-1, for N/LANES cycles per bank.
REQ-026 MAC SHALL clear its accumulator on the first chunk of each bank.
REQ-027 After the last chunk, the FSM SHALL enter OUT with res_valid=1 and res_data and res_bank held stable until res_ready is high.
REQ-028 On OUT with res_ready high, the FSM SHALL go to MAC for bank+1, or to DONE after bank BANKS-1.
REQ-029 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-030 With res_ready tied high, the latency from the start cycle to the first res_valid SHALL be N/LANES+1 cycles, with BANKS*(N/LANES+1)+1 cycles until done.
REQ-031 The accumulator SHALL be RW bits and SHALL not overflow for any operands.
REQ-032 Storage SHALL not change while busy.

Reset
REQ-033 On rst, at any time including mid-operation, the block SHALL enter IDLE and clear all storage and accumulators to 0.
REQ-034 On rst, the outputs SHALL be wr_ready=1, busy=0, res_valid=0, res_data=0, res_bank=0 and done=0.

Configuration
REQ-035 With IMC_SIGNED_EN defined, operands SHALL be two's-complement and res_data SHALL be a signed sign-extended sum.
REQ-036 Without IMC_SIGNED_EN, operands and result SHALL be unsigned; the port list SHALL be identical in both builds.

Structure
REQ-037 Package imc_pkg SHALL hold the FSM state enum, the default parameter constants and a result-width function.
REQ-038 Sub-module imc_mac_lane SHALL hold the LANES multipliers and adder tree (combinational), instantiated once.

Verification (DW=4, N=16, BANKS=4, LANES=4)
REQ-039 All x=15, all banks=15, start, res_ready=1 -> four results of 3600 for banks 0..3, first res_valid 5 cycles after start, done at cycle 21.
REQ-040 x[i]=i, bank0 all 1, bank1[i]=i, banks 2-3 zero -> 120, 1240, 0, 0.
REQ-041 res_ready held low 3 cycles in OUT for bank 1 -> res_data and res_bank stable, no bank-2 result until acceptance.
REQ-042 Write to bank0 and start in the same cycle -> result uses the new data; a write while busy sees wr_ready=0 and storage unchanged.
REQ-043 rst asserted during the MAC of bank 2 -> next cycle IDLE with all outputs at reset values; a subsequent run returns all zeros.
REQ-044 IMC_SIGNED_EN build, x=-8 (4'h8) all, bank0=7 all -> res_data = -896; unsigned build with the same bits -> 896.

Source files
------------

// File: rtl/imc_pkg.sv
// rtl/imc_pkg.sv - shared types, default parameters and helpers for the in-memory-compute engine
//
// Purpose : FSM state encoding, default geometry constants and the result-width
//           helper used by imc_engine and its testbench.
// Ports   : none (package).
package imc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2,
    S_DONE = 2'd3
  } imc_state_t;

  localparam int IMC_DEF_DW    = 4;
  localparam int IMC_DEF_N     = 16;
  localparam int IMC_DEF_BANKS = 4;
  localparam int IMC_DEF_LANES = 4;

  // Wide enough for N full-scale products (signed or unsigned) without overflow.
  function automatic int imc_res_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/imc_mac_lane.sv
// rtl/imc_mac_lane.sv - LANES parallel multipliers feeding one adder tree (combinational)
//
// Purpose : Produces the partial dot product of one LANES-wide chunk.
//           Build option IMC_SIGNED_EN: operands are two's-complement and the
//           sum is sign-extended; otherwise everything is unsigned.
// Ports   : i_x_vec [LANES*DW]  x elements of the chunk, lane l at [l*DW +: DW]
//           i_w_vec [LANES*DW]  weight elements of the chunk, same packing
//           o_sum   [RW]        sum of the LANES products, extended to RW bits
module imc_mac_lane #(
  parameter int DW    = 4,
  parameter int LANES = 4,
  parameter int RW    = 12
) (
  input  logic [LANES*DW-1:0] i_x_vec,
  input  logic [LANES*DW-1:0] i_w_vec,
  output logic [RW-1:0]       o_sum
);

  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
`ifdef IMC_SIGNED_EN
  logic signed [2*DW-1:0] w_prod;
`else
  logic [2*DW-1:0] w_prod;
`endif

  always_comb begin
    o_sum  = '0;
    w_a    = '0;
    w_b    = '0;
    w_prod = '0;
    for (int l = 0; l < LANES; l++) begin
      w_a = i_x_vec[l*DW +: DW];
      w_b = i_w_vec[l*DW +: DW];
`ifdef IMC_SIGNED_EN
      // Operands widened by hand so the product is exact at 2*DW bits; the
      // signed declaration of w_prod makes the RW cast sign-extend.
      w_prod = $signed({{DW{w_a[DW-1]}}, w_a}) * $signed({{DW{w_b[DW-1]}}, w_b});
`else
      w_prod = {{DW{1'b0}}, w_a} * {{DW{1'b0}}, w_b};
`endif
      o_sum = o_sum + RW'(w_prod);
    end
  end

endmodule

// File: rtl/imc_engine.sv
// rtl/imc_engine.sv - register-file dot-product engine: one x vector against BANKS weight banks
//
// Purpose : Holds an x vector and BANKS weight vectors (N elements of DW bits),
//           and on start streams out x.w[b] for b = 0..BANKS-1 with a
//           valid/ready handshake, then pulses done.
//           Build option IMC_SIGNED_EN selects two's-complement arithmetic.
// Ports   : clk, rst (async, active-high)
//           wr_valid/wr_ready/wr_sel/wr_data  vector write (sel 0 = x, k = bank k-1)
//           start                             compute request, honoured in IDLE only
//           busy                              high outside IDLE
//           res_valid/res_ready/res_data/res_bank  per-bank result handshake
//           done                              one-cycle pulse after the last result
module imc_engine
  import imc_pkg::*;
#(
  parameter int DW    = IMC_DEF_DW,
  parameter int N     = IMC_DEF_N,
  parameter int BANKS = IMC_DEF_BANKS,
  parameter int LANES = IMC_DEF_LANES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [$clog2(BANKS+1)-1:0]   wr_sel,
  input  logic [N*DW-1:0]              wr_data,
  input  logic                         start,
  output logic                         busy,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [2*DW+$clog2(N)-1:0]    res_data,
  output logic [$clog2(BANKS)-1:0]     res_bank,
  output logic                         done
);

  localparam int RW     = imc_res_width(DW, N);
  localparam int CHUNKS = N / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int BW     = $clog2(BANKS);
  localparam int SW     = $clog2(BANKS + 1);

  imc_state_t r_state;
  imc_state_t w_next;

  logic [N*DW-1:0] r_x;
  logic [N*DW-1:0] r_w [BANKS];
  logic [CW-1:0]   r_chunk;
  logic [BW-1:0]   r_bank;
  logic [RW-1:0]   r_acc;

  logic                w_wr_fire;
  logic                w_last_chunk;
  logic                w_last_bank;
  logic [LANES*DW-1:0] w_x_chunk;
  logic [LANES*DW-1:0] w_w_chunk;
  logic [RW-1:0]       w_lane_sum;

  assign w_wr_fire    = wr_valid && wr_ready;
  assign w_last_chunk = (r_chunk == CW'(CHUNKS - 1));
  assign w_last_bank  = (r_bank == BW'(BANKS - 1));

  assign w_x_chunk = r_x[32'(r_chunk) * (LANES*DW) +: LANES*DW];
  assign w_w_chunk = r_w[r_bank][32'(r_chunk) * (LANES*DW) +: LANES*DW];

  imc_mac_lane #(
    .DW    (DW),
    .LANES (LANES),
    .RW    (RW)
  ) u_mac_lane (
    .i_x_vec (w_x_chunk),
    .i_w_vec (w_w_chunk),
    .o_sum   (w_lane_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        wr_ready = 1'b1;
        busy     = 1'b0;
        if (start) w_next = S_MAC;
      end
      S_MAC: begin
        if (w_last_chunk) w_next = S_OUT;
      end
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) w_next = w_last_bank ? S_DONE : S_MAC;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Writes are only possible in IDLE (wr_ready), so storage is frozen while
  // busy; a write coinciding with start lands before the first MAC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      for (int b = 0; b < BANKS; b++) r_w[b] <= '0;
      r_chunk <= '0;
      r_bank  <= '0;
      r_acc   <= '0;
    end else begin
      if (w_wr_fire) begin
        if (wr_sel == '0) r_x <= wr_data;
        // Selects above BANKS match no bank and are dropped.
        for (int b = 0; b < BANKS; b++) begin
          if (wr_sel == SW'(b + 1)) r_w[b] <= wr_data;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chunk <= '0;
            r_bank  <= '0;
          end
        end
        S_MAC: begin
          // First chunk of a bank overwrites instead of accumulating.
          r_acc   <= (r_chunk == '0) ? w_lane_sum : r_acc + w_lane_sum;
          r_chunk <= w_last_chunk ? '0 : r_chunk + 1'b1;
        end
        S_OUT: begin
          if (res_ready) r_bank <= w_last_bank ? '0 : r_bank + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign res_data = r_acc;
  assign res_bank = r_bank;

endmodule

// File: tb/tb_imc_engine.sv
// tb/tb_imc_engine.sv - self-checking bench for imc_engine against a timeline/arithmetic model
module tb_imc_engine;

  localparam int DW     = 4;
  localparam int N      = 16;
  localparam int BANKS  = 4;
  localparam int LANES  = 4;
  localparam int RW     = 2*DW + $clog2(N);
  localparam int SW     = $clog2(BANKS + 1);
  localparam int BW     = $clog2(BANKS);
  localparam int CHUNKS = N / LANES;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [SW-1:0]     wr_sel = '0;
  logic [N*DW-1:0]   wr_data = '0;
  logic              start = 1'b0;
  logic              busy;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [RW-1:0]     res_data;
  logic [BW-1:0]     res_bank;
  logic              done;

  always #5 clk = ~clk;

  imc_engine #(.DW(DW), .N(N), .BANKS(BANKS), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
    .start(start), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_bank(res_bank),
    .done(done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int     mx [N];
  int     mw [BANKS][N];
  bit     m_busy = 0;
  int     m_bank = 0;
  int     m_valid_at = 0;
  int     m_done_at = -1;
  longint m_res [BANKS];
  bit     m_ev, m_ed;

  longint cap_q [$];
  int     first_valid_cyc = -1;
  int     done_cyc = -1;
  bit     done_seen = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic longint sval(input int v);
`ifdef IMC_SIGNED_EN
    return (v >= (1 << (DW-1))) ? longint'(v - (1 << DW)) : longint'(v);
`else
    return longint'(v);
`endif
  endfunction

  function automatic longint rwbits(input longint s);
    return s & ((longint'(1) << RW) - 1);
  endfunction

  function automatic logic [N*DW-1:0] fill(input int v);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [N*DW-1:0] ramp();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(i);
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a start in IDLE yields bank b's result after CHUNKS+1 cycles from
  // the start or from the previous acceptance; done follows the last acceptance.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_bank", res_bank, 0);
      chk("rst_done", done, 0);
      for (int i = 0; i < N; i++) begin
        mx[i] = 0;
        for (int b = 0; b < BANKS; b++) mw[b][i] = 0;
      end
      m_busy = 0;
      m_done_at = -1;
    end else begin
      m_ev = m_busy && (m_done_at < 0) && (cyc >= m_valid_at);
      m_ed = m_busy && (cyc == m_done_at);
      chk("busy", busy, m_busy);
      chk("wr_ready", wr_ready, !m_busy);
      chk("res_valid", res_valid, m_ev);
      chk("done", done, m_ed);
      if (m_ev) begin
        chk("res_data", res_data, rwbits(m_res[m_bank]));
        chk("res_bank", res_bank, m_bank);
      end
      if (res_valid && res_ready) cap_q.push_back(longint'(res_data));
      if (res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      if (!m_busy) begin
        if (wr_valid) begin
          for (int i = 0; i < N; i++) begin
            if (int'(wr_sel) == 0) mx[i] = int'(wr_data[i*DW +: DW]);
            else if (int'(wr_sel) <= BANKS) mw[int'(wr_sel)-1][i] = int'(wr_data[i*DW +: DW]);
          end
        end
        if (start) begin
          for (int b = 0; b < BANKS; b++) begin
            m_res[b] = 0;
            for (int i = 0; i < N; i++) m_res[b] += sval(mx[i]) * sval(mw[b][i]);
          end
          m_busy = 1;
          m_bank = 0;
          m_valid_at = cyc + 1 + CHUNKS;
          m_done_at = -1;
        end
      end else if (m_ed) begin
        m_busy = 0;
      end else if (m_ev && res_ready) begin
        if (m_bank == BANKS - 1) m_done_at = cyc + 1;
        else begin
          m_bank++;
          m_valid_at = cyc + 1 + CHUNKS;
        end
      end
    end
  end

  task automatic write_vec(input int sel, input logic [N*DW-1:0] d);
    wr_valid = 1'b1;
    wr_sel   = SW'(sel);
    wr_data  = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  // mode 0: ready high; 1: random ready and pokes while busy;
  // 2: ready low 3 cycles on bank 1; 3: write attempt while busy
  task automatic go(input int mode, input bit wr, input int sel, input logic [N*DW-1:0] d,
                    output int t0);
    int hold;
    cap_q.delete();
    first_valid_cyc = -1;
    done_cyc = -1;
    done_seen = 0;
    hold = 0;
    t0 = cyc;
    start = 1'b1;
    if (wr) begin
      wr_valid = 1'b1;
      wr_sel   = SW'(sel);
      wr_data  = d;
    end
    @(posedge clk); #1;
    start = 1'b0;
    wr_valid = 1'b0;
    for (int i = 0; i < 2000 && !done_seen; i++) begin
      start = 1'b0;
      wr_valid = 1'b0;
      res_ready = 1'b1;
      case (mode)
        1: begin
          res_ready = 1'($urandom_range(0, 1));
          if (busy && !done) begin
            start    = ($urandom_range(0, 3) == 0);
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_sel   = SW'($urandom_range(0, 7));
            wr_data  = {$urandom(), $urandom()};
          end
        end
        2: begin
          if (res_valid && res_bank == BW'(1) && hold < 3) begin
            res_ready = 1'b0;
            hold++;
          end
        end
        3: begin
          if (i == 1) begin
            wr_valid = 1'b1;
            wr_sel   = SW'(2);
            wr_data  = fill(15);
            chk("busy_wr_ready", wr_ready, 0);
          end
        end
        default: ;
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0;
    wr_valid = 1'b0;
    res_ready = 1'b1;
    chk("run_done_seen", done_seen, 1);
  endtask

  task automatic chk_results(input string nm, input longint e0, input longint e1,
                             input longint e2, input longint e3);
    chk({nm, "_count"}, cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk({nm, "_b0"}, cap_q[0], rwbits(e0));
      chk({nm, "_b1"}, cap_q[1], rwbits(e1));
      chk({nm, "_b2"}, cap_q[2], rwbits(e2));
      chk({nm, "_b3"}, cap_q[3], rwbits(e3));
    end
  endtask

  initial begin
    int  t0;
    bit  found;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // All fifteens
    write_vec(0, fill(15));
    for (int b = 1; b <= BANKS; b++) write_vec(b, fill(15));
    go(0, 0, 0, '0, t0);
`ifdef IMC_SIGNED_EN
    chk_results("all15", 16, 16, 16, 16);
`else
    chk_results("all15", 3600, 3600, 3600, 3600);
`endif
    chk("first_valid_latency", first_valid_cyc - t0, 5);
    chk("done_latency", done_cyc - t0, 21);

    // Ramp patterns, bank 1 result held unaccepted for 3 cycles
    write_vec(0, ramp());
    write_vec(1, fill(1));
    write_vec(2, ramp());
    write_vec(3, fill(0));
    write_vec(4, fill(0));
    write_vec(7, fill(9));   // discarded select
    go(2, 0, 0, '0, t0);
`ifdef IMC_SIGNED_EN
    chk_results("ramp", -8, 344, 0, 0);
`else
    chk_results("ramp", 120, 1240, 0, 0);
`endif
    chk("stall_done_latency", done_cyc - t0, 24);

    // Write coinciding with start, then a rejected write while busy
    write_vec(0, fill(1));
    write_vec(2, fill(3));
    go(3, 1, 1, fill(2), t0);
    chk("coincident_b0", (cap_q.size() > 0) ? cap_q[0] : -1, 32);
    chk("before_poke_b1", (cap_q.size() > 1) ? cap_q[1] : -1, 48);
    go(0, 0, 0, '0, t0);
    chk("after_poke_b1", (cap_q.size() > 1) ? cap_q[1] : -1, 48);

    // Reset during bank 2 accumulation
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (busy && !res_valid && res_bank == BW'(2)) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("reached_bank2_mac", found, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_ready", wr_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    go(0, 0, 0, '0, t0);
    chk_results("after_rst", 0, 0, 0, 0);

    // Most-negative x against a positive weight
    write_vec(0, fill(8));
    write_vec(1, fill(7));
    go(0, 0, 0, '0, t0);
`ifdef IMC_SIGNED_EN
    chk("neg8x7", (cap_q.size() > 0) ? cap_q[0] : -1, rwbits(-896));
`else
    chk("neg8x7", (cap_q.size() > 0) ? cap_q[0] : -1, 896);
`endif

    // Randomized runs
    for (int r = 0; r < 30; r++) begin
      int nw;
      nw = $urandom_range(0, 6);
      for (int k = 0; k < nw; k++) write_vec($urandom_range(0, 7), {$urandom(), $urandom()});
      go(1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), {$urandom(), $urandom()}, t0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
